// File: rtl/debug_monitor_pkg.sv
// Shared encodings for the debug viewer / run-control unit.
package debug_monitor_pkg;

  typedef enum logic [1:0] {
    MODE_MANUAL = 2'b00,
    MODE_SCAN   = 2'b01,
    MODE_FREEZE = 2'b10
  } mode_e;

  typedef enum logic [1:0] {
    SPEED_FULL = 2'b00,
    SPEED_DIV0 = 2'b01,
    SPEED_DIV1 = 2'b10,
    SPEED_DIV2 = 2'b11
  } speed_e;

  // The unused 2'b11 encoding behaves exactly like manual mode.
  function automatic mode_e decodeMode(input logic [1:0] m);
    case (m)
      2'b01:   return MODE_SCAN;
      2'b10:   return MODE_FREEZE;
      default: return MODE_MANUAL;
    endcase
  endfunction

endpackage

// File: rtl/debug_monitor_key_debouncer.sv
// Push-button conditioner: 2-FF synchroniser, stability window and a
// one-cycle pulse on each debounced press (released -> pressed).
module key_debouncer #(
  parameter int DB_CYCLES = 50000
) (
  input  logic clock,
  input  logic resetn,
  input  logic i_key_n,
  output logic o_press
);

  localparam int CNT_W = $clog2(DB_CYCLES + 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_press;

  // Bring the raw asynchronous key into the clock domain; idle level is released (1).
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_key_n;
      r_sync2 <= r_sync1;
    end
  end

  // Accept a new level only after DB_CYCLES consecutive differing samples; a matching sample restarts the window.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= 1'b1;
      r_cnt   <= '0;
      r_press <= 1'b0;
    end else if (r_sync2 != r_state) begin
      if (r_cnt == CNT_W'(DB_CYCLES - 1)) begin
        r_state <= r_sync2;
        r_cnt   <= '0;
        r_press <= ~r_sync2;
      end else begin
        r_cnt   <= r_cnt + CNT_W'(1);
        r_press <= 1'b0;
      end
    end else begin
      r_cnt   <= '0;
      r_press <= 1'b0;
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/debug_monitor.sv
// Debug viewer (manual / auto-scan / freeze) and run-enable generator
// for the design under debug, which stays on the system clock.
module debug_monitor
  import debug_monitor_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int WORDS     = 16,
  parameter int BANKS     = 2,
  parameter int DIV_W     = 23,
  parameter int DB_CYCLES = 50000,
  parameter int DWELL     = 50000000
) (
  input  logic                                       clock,
  input  logic                                       resetn,
  input  logic [BANKS*WORDS*WIDTH-1:0]               probes,
  input  logic [((BANKS > 1) ? $clog2(BANKS) : 1)-1:0] sel_bank,
  input  logic [$clog2(WORDS)-1:0]                   sel_word,
  input  logic [1:0]                                 mode,
  input  logic                                       capture,
  input  logic [1:0]                                 speed,
  input  logic                                       lock,
  input  logic                                       step_key,
  output logic [WIDTH-1:0]                           view_word,
  output logic [((BANKS > 1) ? $clog2(BANKS) : 1)-1:0] view_bank,
  output logic [$clog2(WORDS)-1:0]                   view_index,
  output logic                                       frozen,
  output logic                                       run_en,
  output logic [15:0]                                step_count
);

  localparam int BANK_W  = (BANKS > 1) ? $clog2(BANKS) : 1;
  localparam int IDX_W   = $clog2(WORDS);
  localparam int DWELL_W = $clog2(DWELL) + 1;

  mode_e              r_mode;
  mode_e              w_mode;
  logic               w_mode_entry;
  logic [BANK_W-1:0]  w_bank_cl;
  logic [WIDTH-1:0]   w_sel_word;
  logic [WIDTH-1:0]   w_ptr_word;
  logic [BANK_W-1:0]  r_ptr_bank;
  logic [IDX_W-1:0]   r_ptr_idx;
  logic [DWELL_W-1:0] r_dwell;
  logic               w_dwell_done;
  logic               r_cap_q;
  logic               r_cap_qq;
  logic               w_cap_edge;
  logic [WIDTH-1:0]   r_view_word;
  logic [BANK_W-1:0]  r_view_bank;
  logic [IDX_W-1:0]   r_view_index;
  logic               r_frozen;
  logic [DIV_W-1:0]   r_div;
  logic [2:0]         r_tap_prev;
  logic [2:0]         w_tap_rise;
  logic               w_press;
  logic               w_run_next;
  logic               r_run_en;
  logic [15:0]        r_step_count;

  assign w_mode       = decodeMode(mode);
  assign w_mode_entry = (w_mode != r_mode);
  assign w_bank_cl    = (sel_bank > BANK_W'(BANKS - 1)) ? BANK_W'(BANKS - 1) : sel_bank;
  assign w_sel_word   = probes[(int'(w_bank_cl) * WORDS + int'(sel_word)) * WIDTH +: WIDTH];
  assign w_ptr_word   = probes[(int'(r_ptr_bank) * WORDS + int'(r_ptr_idx)) * WIDTH +: WIDTH];
  assign w_dwell_done = (r_dwell == DWELL_W'(DWELL - 1));
  assign w_cap_edge   = r_cap_q & ~r_cap_qq;
  assign w_tap_rise   = r_div[DIV_W-1 -: 3] & ~r_tap_prev;

  // Remember the last decoded mode so a mode entry can be recognised.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) r_mode <= MODE_MANUAL;
    else         r_mode <= w_mode;
  end

  // Delay the capture input twice so its rising edge is seen one cycle later.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_cap_q  <= 1'b0;
      r_cap_qq <= 1'b0;
    end else begin
      r_cap_q  <= capture;
      r_cap_qq <= r_cap_q;
    end
  end

  // Scan pointer: loads from the clamped selects on entry, then walks word-major every DWELL cycles.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_ptr_bank <= '0;
      r_ptr_idx  <= '0;
      r_dwell    <= '0;
    end else if (w_mode == MODE_SCAN) begin
      if (w_mode_entry) begin
        r_ptr_bank <= w_bank_cl;
        r_ptr_idx  <= sel_word;
        r_dwell    <= '0;
      end else if (w_dwell_done) begin
        r_dwell <= '0;
        if (r_ptr_idx == IDX_W'(WORDS - 1)) begin
          r_ptr_idx  <= '0;
          r_ptr_bank <= (r_ptr_bank == BANK_W'(BANKS - 1)) ? '0 : r_ptr_bank + BANK_W'(1);
        end else begin
          r_ptr_idx <= r_ptr_idx + IDX_W'(1);
        end
      end else begin
        r_dwell <= r_dwell + DWELL_W'(1);
      end
    end
  end

  // Displayed word and its location; mode entry wins over a capture edge in the same cycle.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_view_word  <= '0;
      r_view_bank  <= '0;
      r_view_index <= '0;
      r_frozen     <= 1'b0;
    end else begin
      case (w_mode)
        MODE_SCAN: begin
          r_frozen <= 1'b0;
          if (w_mode_entry) begin
            r_view_word  <= w_sel_word;
            r_view_bank  <= w_bank_cl;
            r_view_index <= sel_word;
          end else begin
            r_view_word  <= w_ptr_word;
            r_view_bank  <= r_ptr_bank;
            r_view_index <= r_ptr_idx;
          end
        end
        MODE_FREEZE: begin
          if (w_mode_entry) begin
            r_frozen <= 1'b0;
          end else if (w_cap_edge) begin
            r_view_word  <= w_sel_word;
            r_view_bank  <= w_bank_cl;
            r_view_index <= sel_word;
            r_frozen     <= 1'b1;
          end
        end
        default: begin
          r_frozen     <= 1'b0;
          r_view_word  <= w_sel_word;
          r_view_bank  <= w_bank_cl;
          r_view_index <= sel_word;
        end
      endcase
    end
  end

  // Free-running divider; the top three bits are tracked together so a speed change cannot fake an edge.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_div      <= '0;
      r_tap_prev <= '0;
    end else begin
      r_div      <= r_div + DIV_W'(1);
      r_tap_prev <= r_div[DIV_W-1 -: 3];
    end
  end

  key_debouncer #(
    .DB_CYCLES(DB_CYCLES)
  ) u_key_debouncer (
    .clock   (clock),
    .resetn  (resetn),
    .i_key_n (step_key),
    .o_press (w_press)
  );

  // Pick the run source: debounced press when locked, otherwise the selected divider rate.
  always_comb begin
    w_run_next = 1'b0;
    if (lock) begin
      w_run_next = w_press;
    end else begin
      case (speed_e'(speed))
        SPEED_FULL: w_run_next = 1'b1;
        SPEED_DIV0: w_run_next = w_tap_rise[0];
        SPEED_DIV1: w_run_next = w_tap_rise[1];
        default:    w_run_next = w_tap_rise[2];
      endcase
    end
  end

  // Register the run enable and count every cycle it was asserted.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_run_en     <= 1'b0;
      r_step_count <= '0;
    end else begin
      r_run_en     <= w_run_next;
      r_step_count <= r_step_count + 16'(r_run_en);
    end
  end

  assign view_word  = r_view_word;
  assign view_bank  = r_view_bank;
  assign view_index = r_view_index;
  assign frozen     = r_frozen;
  assign run_en     = r_run_en;
  assign step_count = r_step_count;

endmodule

// File: tb/tb_debug_monitor.sv
// Directed bench for debug_monitor with small parameters.
module tb_debug_monitor;
  import debug_monitor_pkg::*;

  localparam int WIDTH     = 8;
  localparam int WORDS     = 4;
  localparam int BANKS     = 3;
  localparam int DIV_W     = 6;
  localparam int DB_CYCLES = 4;
  localparam int DWELL     = 3;

  logic                         clock = 1'b0;
  logic                         resetn;
  logic [BANKS*WORDS*WIDTH-1:0] probes;
  logic [1:0]                   sel_bank;
  logic [1:0]                   sel_word;
  logic [1:0]                   mode;
  logic                         capture;
  logic [1:0]                   speed;
  logic                         lock;
  logic                         step_key;
  logic [WIDTH-1:0]             view_word;
  logic [1:0]                   view_bank;
  logic [1:0]                   view_index;
  logic                         frozen;
  logic                         run_en;
  logic [15:0]                  step_count;

  int assertCount = 0;
  int failCount   = 0;
  int pulses;
  int found;

  debug_monitor #(
    .WIDTH(WIDTH), .WORDS(WORDS), .BANKS(BANKS),
    .DIV_W(DIV_W), .DB_CYCLES(DB_CYCLES), .DWELL(DWELL)
  ) dut (
    .clock(clock), .resetn(resetn), .probes(probes),
    .sel_bank(sel_bank), .sel_word(sel_word), .mode(mode),
    .capture(capture), .speed(speed), .lock(lock), .step_key(step_key),
    .view_word(view_word), .view_bank(view_bank), .view_index(view_index),
    .frozen(frozen), .run_en(run_en), .step_count(step_count)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [1:0] m, input logic [1:0] b, input logic [1:0] w);
    mode     = m;
    sel_bank = b;
    sel_word = w;
  endtask

  task automatic setProbe(input int b, input int w, input logic [7:0] v);
    probes[(b*WORDS + w)*WIDTH +: WIDTH] = v;
  endtask

  task automatic countRunEn(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      tick(1);
      if (run_en === 1'b1) cnt++;
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_word"},  32'(view_word),  32'h0);
    checkOutput({tag, "_bank"},  32'(view_bank),  32'h0);
    checkOutput({tag, "_index"}, 32'(view_index), 32'h0);
    checkOutput({tag, "_frozen"}, 32'(frozen),    32'h0);
    checkOutput({tag, "_run_en"}, 32'(run_en),    32'h0);
    checkOutput({tag, "_count"}, 32'(step_count), 32'h0);
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    resetn   = 1'b0;
    capture  = 1'b0;
    speed    = 2'b00;
    lock     = 1'b1;
    step_key = 1'b1;
    applyStimulus(MODE_MANUAL, 2'd0, 2'd0);
    for (int b = 0; b < BANKS; b++)
      for (int w = 0; w < WORDS; w++)
        setProbe(b, w, 8'(8'h40 + b*16 + w));
    tick(2);
    checkAllZero("reset");
    resetn = 1'b1;

    // Manual selection and bank clamping
    setProbe(2, 1, 8'hA5);
    applyStimulus(MODE_MANUAL, 2'd2, 2'd1);
    tick(1);
    checkOutput("manual_word",  32'(view_word),  32'hA5);
    checkOutput("manual_bank",  32'(view_bank),  32'd2);
    checkOutput("manual_index", 32'(view_index), 32'd1);
    applyStimulus(MODE_MANUAL, 2'd3, 2'd1);
    tick(1);
    checkOutput("clamp_bank", 32'(view_bank), 32'd2);
    checkOutput("clamp_word", 32'(view_word), 32'hA5);

    // Auto-scan from bank 1 word 3
    applyStimulus(MODE_SCAN, 2'd1, 2'd3);
    tick(1);
    checkOutput("scan_entry_loc",  {30'd0, view_bank} * 4 + 32'(view_index), 32'd7);
    checkOutput("scan_entry_word", 32'(view_word), 32'h53);
    tick(3);
    checkOutput("scan_hold_loc", {30'd0, view_bank} * 4 + 32'(view_index), 32'd7);
    tick(1);
    checkOutput("scan_2_0_loc",  {30'd0, view_bank} * 4 + 32'(view_index), 32'd8);
    checkOutput("scan_2_0_word", 32'(view_word), 32'h60);
    tick(3);
    checkOutput("scan_2_1_word", 32'(view_word), 32'hA5);
    tick(3);
    checkOutput("scan_2_2_loc",  {30'd0, view_bank} * 4 + 32'(view_index), 32'd10);
    tick(3);
    checkOutput("scan_2_3_word", 32'(view_word), 32'h63);
    tick(3);
    checkOutput("scan_wrap_loc",  {30'd0, view_bank} * 4 + 32'(view_index), 32'd0);
    checkOutput("scan_wrap_word", 32'(view_word), 32'h40);

    // Freeze with capture and re-capture
    setProbe(0, 2, 8'h3C);
    applyStimulus(MODE_FREEZE, 2'd0, 2'd2);
    tick(1);
    checkOutput("freeze_entry_frozen", 32'(frozen),    32'd0);
    checkOutput("freeze_entry_hold",   32'(view_word), 32'h40);
    capture = 1'b1;
    tick(1);
    checkOutput("capture_latency", 32'(frozen), 32'd0);
    tick(1);
    checkOutput("capture_frozen", 32'(frozen),     32'd1);
    checkOutput("capture_word",   32'(view_word),  32'h3C);
    checkOutput("capture_index",  32'(view_index), 32'd2);
    setProbe(0, 2, 8'hFF);
    capture = 1'b0;
    tick(1);
    checkOutput("freeze_hold_word", 32'(view_word), 32'h3C);
    capture = 1'b1;
    tick(2);
    checkOutput("recapture_word", 32'(view_word), 32'hFF);
    capture = 1'b0;
    applyStimulus(MODE_MANUAL, 2'd0, 2'd2);
    tick(1);
    checkOutput("leave_freeze_frozen", 32'(frozen), 32'd0);

    // Locked single step with a bouncing key
    pulses = 0;
    step_key = 1'b0; tick(1); if (run_en) pulses++;
    step_key = 1'b1; tick(1); if (run_en) pulses++;
    step_key = 1'b0; tick(1); if (run_en) pulses++;
    for (int i = 0; i < 10; i++) begin tick(1); if (run_en) pulses++; end
    step_key = 1'b1;
    for (int i = 0; i < 10; i++) begin tick(1); if (run_en) pulses++; end
    checkOutput("bounce_pulses", 32'(pulses),     32'd1);
    checkOutput("bounce_count",  32'(step_count), 32'd1);

    // Divided and full-rate run
    lock  = 1'b0;
    speed = 2'b11;
    countRunEn(256, pulses);
    checkOutput("speed11_pulses", 32'(pulses), 32'd4);
    speed = 2'b00;
    tick(1);
    countRunEn(10, pulses);
    checkOutput("speed00_pulses", 32'(pulses), 32'd10);

    // Step counter wrap
    found = 0;
    for (int i = 0; i < 70000; i++) begin
      if (step_count == 16'hFFFF) begin
        found = 1;
        break;
      end
      tick(1);
    end
    checkOutput("wrap_reach", 32'(found), 32'd1);
    tick(1);
    checkOutput("wrap_zero", 32'(step_count), 32'd0);

    // Reset mid-scan and mid-debounce, then a full window is needed
    applyStimulus(MODE_SCAN, 2'd0, 2'd0);
    tick(5);
    lock     = 1'b1;
    step_key = 1'b0;
    tick(3);
    resetn = 1'b0;
    #1;
    checkAllZero("midreset");
    tick(1);
    resetn = 1'b1;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin tick(1); if (run_en) pulses++; end
    checkOutput("post_reset_early", 32'(pulses), 32'd0);
    tick(1);
    checkOutput("post_reset_pulse", 32'(run_en), 32'd1);
    step_key = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/debug_monitor.md
# debug_monitor

Parametrised debug viewer and run-control unit for the flow board top level. It selects one word from a flattened multi-bank probe bus for seven-segment display, in manual, auto-scan or frozen-snapshot mode. It also generates a run-enable pulse for the design under debug, either free-running at a selectable divided rate or single-stepped from a debounced key. It replaces the gated divided clock with a clock-enable, so the design under debug stays on `clock`.

## Interface
- `WIDTH`, 16: bits per probe word; multiple of 4.
- `WORDS`, 16: words per bank; ≥2.
- `BANKS`, 2: number of banks; ≥1, need not be a power of two.
- `DIV_W`, 23: free-running divider width; ≥4.
- `DB_CYCLES`, 50000: debounce stability window in cycles.
- `DWELL`, 50000000: auto-scan dwell in cycles; ≥1.
- `clock`  in  1  system clock.
- `resetn`  in  1  reset, asynchronous, active-low.
- `probes`  in  BANKS*WORDS*WIDTH  flattened probe bus; word w of bank b sits at `[(b*WORDS+w)*WIDTH +: WIDTH]`.
- `sel_bank`  in  max(1,clog2(BANKS))  manual bank select.
- `sel_word`  in  clog2(WORDS)  manual word select.
- `mode`  in  2  00 manual, 01 auto-scan, 10 freeze, 11 treated as manual.
- `capture`  in  1  freeze trigger; rising-edge sensitive.
- `speed`  in  2  run-rate select.
- `lock`  in  1  1 = run only by single step.
- `step_key`  in  1  raw push button, active-low, asynchronous.
- `view_word`  out  WIDTH  displayed word.
- `view_bank`  out  max(1,clog2(BANKS))  bank of displayed word.
- `view_index`  out  clog2(WORDS)  index of displayed word.
- `frozen`  out  1  snapshot valid in freeze mode.
- `run_en`  out  1  one-cycle enable for the design under debug.
- `step_count`  out  16  count of `run_en` pulses, wrapping.

## Operation
- Reset: all outputs 0. Debounced key state is 1 (released). Divider, dwell counter and edge detectors are cleared.
- `sel_bank` ≥ BANKS is clamped to BANKS-1.
- Manual: view_bank/view_index follow the clamped selects. `view_word` is the registered probe word.
- Auto-scan: on entry, the pointer loads from the clamped selects and the dwell counter clears. Every DWELL cycles, the index increments. When the index wraps from WORDS-1 to 0, the bank increments, wrapping from BANKS-1 to 0. `view_word` tracks live probes at the pointer.
- Freeze: on entry, `frozen`=0 and `view_word` holds its last value. A capture rising edge loads the word at the clamped selects, updates view_bank/view_index and sets `frozen`=1. Later edges re-capture. Leaving freeze clears `frozen`.
- Mode change takes priority over a dwell expiry or capture edge in the same cycle.
- Run control, lock=0: speed 00 gives `run_en`=1 every cycle. Speeds 01/10/11 give one pulse each time divider bit DIV_W-3/DIV_W-2/DIV_W-1 rises. A speed change does not reset the divider.
- Run control, lock=1: the divided pulses are suppressed. Each debounced press (1→0) gives exactly one `run_en` pulse. Presses while lock=0 are ignored.
- Debounce: `step_key` passes through a 2-FF synchroniser. The debounced state changes only after DB_CYCLES consecutive synchronised samples differ from it. Any matching sample restarts the window.
- `step_count` increments on every `run_en` cycle and wraps from FFFF to 0.

## Timing
- view_* outputs: 1 cycle latency from probes, selects and pointer.
- Capture: edge detected 1 cycle after the synchronous `capture` input rises; snapshot is visible the following cycle.
- Step: the `run_en` pulse occurs at synchronizer (2) + DB_CYCLES + 1 cycles after a clean press.
- Divided run: period is 2^(DIV_W-2), 2^(DIV_W-1) or 2^DIV_W cycles.
- Toggling lock mid-debounce does not disturb the debouncer.
- Reset asserted at any time returns every output to 0 immediately.

## Structure
- Package `debug_monitor_pkg` holds the mode encodings (MODE_MANUAL, MODE_SCAN, MODE_FREEZE) and the speed encodings.
- Sub-module `key_debouncer`: synchroniser, stability counter and press-pulse output, parameterised by DB_CYCLES.
- Divider, scan pointer, freeze register and step counter live in `debug_monitor`.

## Test plan
Bench parameters: WIDTH=8, WORDS=4, BANKS=3, DIV_W=6, DB_CYCLES=4, DWELL=3.
- Manual, probe word (b=2,w=1)=0xA5, sel=2/1 → `view_word`=A5 next cycle; sel_bank=3 → clamped, view_bank=2.
- Auto-scan from 1/3 → after 3 cycles shows 2/0; continues 2/1..2/3, then 0/0.
- Freeze: probe (0,2)=0x3C, capture edge → `frozen`=1, 0x3C held while probe changes to 0xFF; mode→manual clears `frozen`.
- lock=1, key bounce 1-0-1-0 within 3 cycles then low for 10 cycles → exactly one `run_en` pulse; `step_count`=1.
- lock=0, speed=11 for 256 cycles → 4 pulses; speed=00 for 10 cycles → 10 pulses; `step_count` wraps FFFF→0.
- Reset mid-scan and mid-debounce → all outputs 0; next press needs a full DB_CYCLES window.
